// File: rtl/pixel_axis_packer.sv
// pixel_axis_packer: frames the recovered 8-bit pixel stream into lines and
// frames, packs four pixels per 32-bit word and presents them on an
// AXI4-Stream master (tuser = start of frame, tlast = end of line).
// A small FIFO absorbs backpressure; on overflow the rest of the frame is
// dropped until the next frame_start.
module pixel_axis_packer #(
  parameter int LINE_WIDTH  = 640,
  parameter int FRAME_LINES = 480,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk_slow,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [7:0]  data,
  input  logic        valid,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam int PIX_W  = $clog2(LINE_WIDTH);
  localparam int LINE_W = $clog2(FRAME_LINES + 1);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_WIDTH - 1);
  localparam logic [PIX_W-1:0]  PIX_WORD0 = PIX_W'(3);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [CNT_W:0]    DEPTH_OCC = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  // framing state
  state_t            state_reg;
  logic [1:0]        byte_cnt_reg;
  logic [PIX_W-1:0]  pix_cnt_reg;
  logic [LINE_W-1:0] line_cnt_reg;
  logic [23:0]       pack_bytes;

  // word staged for the FIFO write one edge after completion
  logic              stage_valid_reg;
  logic [33:0]       stage_word_reg;
  logic              stage_fend_reg;

  // FIFO storage plus the registered output slot
  logic [33:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]  mem_count_reg;
  logic              out_valid_reg;
  logic [33:0]       out_word_reg;

  logic              overflow_reg;
  logic [15:0]       frame_count_reg;

  // effective counters: frame_start restarts the frame at pixel 0 this cycle
  logic [1:0]        byte_eff;
  logic [PIX_W-1:0]  pix_eff;
  logic [LINE_W-1:0] line_eff;
  logic              accept_byte;
  logic              word_done;
  logic              line_end;
  logic              frame_end;
  logic              word_user;

  logic              pop;
  logic [CNT_W:0]    occupancy;
  logic              push_ok;
  logic              drop;
  logic              load_out;

  // Decode where the incoming byte lands and whether it closes a word/line/frame
  always_comb begin
    byte_eff    = frame_start ? 2'd0 : byte_cnt_reg;
    pix_eff     = frame_start ? '0 : pix_cnt_reg;
    line_eff    = frame_start ? '0 : line_cnt_reg;
    accept_byte = valid && (frame_start || (state_reg == ACTIVE));
    word_done   = accept_byte && (byte_eff == 2'd3);
    line_end    = word_done && (pix_eff == PIX_LAST);
    frame_end   = line_end && (line_eff == LINE_LAST);
    word_user   = word_done && (pix_eff == PIX_WORD0) && (line_eff == '0);
  end

  // FIFO handshake: a full FIFO still accepts a push if it pops the same cycle
  always_comb begin
    pop       = out_valid_reg && m_axis_tready;
    occupancy = {1'b0, mem_count_reg} + (CNT_W + 1)'(out_valid_reg);
    push_ok   = stage_valid_reg && ((occupancy < DEPTH_OCC) || pop);
    drop      = stage_valid_reg && !push_ok;
    load_out  = (mem_count_reg != '0) && (!out_valid_reg || pop);
  end

  // Frame state machine and pixel/line counters
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      state_reg    <= IDLE;
      byte_cnt_reg <= '0;
      pix_cnt_reg  <= '0;
      line_cnt_reg <= '0;
    end else begin
      if (frame_start) begin
        state_reg <= ACTIVE;
      end else if (drop) begin
        state_reg <= DROP;
      end else if (frame_end) begin
        state_reg <= IDLE;
      end

      if (accept_byte) begin
        byte_cnt_reg <= byte_eff + 2'd1;
        pix_cnt_reg  <= line_end ? '0 : pix_eff + PIX_W'(1);
        line_cnt_reg <= line_end ? line_eff + LINE_W'(1) : line_eff;
      end else if (frame_start) begin
        byte_cnt_reg <= '0;
        pix_cnt_reg  <= '0;
        line_cnt_reg <= '0;
      end
    end
  end

  // Byte lanes 0..2 of the pack register; lane 3 goes straight into the word
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic [7:0] lane_reg;

      // Capture the byte addressed to this lane
      always_ff @(posedge clk_slow) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (accept_byte && (byte_eff == 2'(gi))) begin
          lane_reg <= data;
        end
      end

      assign pack_bytes[8*gi +: 8] = lane_reg;
    end
  endgenerate

  // Stage the completed word with its {user, last} flags
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      stage_valid_reg <= 1'b0;
      stage_word_reg  <= '0;
      stage_fend_reg  <= 1'b0;
    end else begin
      stage_valid_reg <= word_done;
      stage_word_reg  <= {word_user, line_end, data, pack_bytes};
      stage_fend_reg  <= frame_end;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk_slow) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= stage_word_reg;
    end
  end

  // FIFO pointers and stored-word count
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_count_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (load_out) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      mem_count_reg <= mem_count_reg + CNT_W'(push_ok) - CNT_W'(load_out);
    end
  end

  // Registered read into the output slot; held while the sink stalls
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_word_reg  <= '0;
    end else if (load_out) begin
      out_valid_reg <= 1'b1;
      out_word_reg  <= mem[rd_ptr_reg];
    end else if (pop) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Sticky overflow flag and completed-frame counter
  always_ff @(posedge clk_slow) begin
    if (rst) begin
      overflow_reg    <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (push_ok && stage_fend_reg) begin
        frame_count_reg <= frame_count_reg + 16'd1;
      end
    end
  end

  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tdata  = out_word_reg[31:0];
  assign m_axis_tlast  = out_word_reg[32];
  assign m_axis_tuser  = out_word_reg[33];
  assign overflow      = overflow_reg;
  assign frame_count   = frame_count_reg;

endmodule

// File: tb/tb_pixel_axis_packer.sv
// Bench for pixel_axis_packer: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a pixel-level
// reference model (frame position arithmetic + a queue for the FIFO).
module tb_pixel_axis_packer;

  localparam int LW    = 8;
  localparam int FL    = 2;
  localparam int DEPTH = 4;

  logic        clk_slow;
  logic        rst;
  logic        frame_start;
  logic [7:0]  data;
  logic        valid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        overflow;
  logic [15:0] frame_count;

  pixel_axis_packer #(
    .LINE_WIDTH (LW),
    .FRAME_LINES(FL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_slow     (clk_slow),
    .rst          (rst),
    .frame_start  (frame_start),
    .data         (data),
    .valid        (valid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .overflow     (overflow),
    .frame_count  (frame_count)
  );

  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [33:0] w;
    int          edge_no;
  } ent_t;

  ent_t        q[$];          // every word held by the FIFO, head = presented word
  int          edge_no = 0;   // posedges seen so far
  bit          model_live = 0;
  int          m_state = 0;   // 0 idle, 1 active, 2 drop
  int          m_pix = 0;     // pixel index within the frame
  logic [31:0] m_acc = '0;
  bit          m_pend = 0;    // completed word waiting for its FIFO write
  logic [33:0] m_pend_w = '0;
  bit          m_pend_fend = 0;
  bit          m_ovf = 0;
  logic [15:0] m_fc = '0;

  logic [33:0] obs[$];        // beats seen on the stream, for literal checks
  bit          stall_pending = 0;
  logic [33:0] stall_word = '0;

  // A word written at edge E is first visible after edge E+1
  function automatic bit exp_tvalid(input int k);
    return (q.size() > 0) && (q[0].edge_no < k);
  endfunction

  initial begin
    forever begin
      @(posedge clk_slow);
      if (!rst && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
        obs.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      stall_pending = !rst && (m_axis_tvalid === 1'b1) && !m_axis_tready;
      stall_word    = {m_axis_tuser, m_axis_tlast, m_axis_tdata};

      if (rst) begin
        edge_no++;
        q.delete();
        m_state = 0; m_pix = 0; m_pend = 0; m_ovf = 0; m_fc = '0;
        model_live = 1;
      end else if (model_live) begin
        bit pop;
        bit drop;
        int st_before;
        pop  = exp_tvalid(edge_no) && m_axis_tready;
        edge_no++;
        drop = 0;
        if (pop) void'(q.pop_front());
        if (m_pend) begin
          if (q.size() < DEPTH) begin
            ent_t e;
            e.w = m_pend_w;
            e.edge_no = edge_no;
            q.push_back(e);
            if (m_pend_fend) m_fc++;
          end else begin
            drop  = 1;
            m_ovf = 1;
          end
        end
        m_pend = 0;
        st_before = m_state;
        if (frame_start) begin
          m_state = 1;
          m_pix   = 0;
        end else if (drop) begin
          m_state = 2;
        end
        if (valid && (frame_start || st_before == 1)) begin
          int lane;
          lane = m_pix % 4;
          m_acc[8*lane +: 8] = data;
          m_pix++;
          if (lane == 3) begin
            bit user;
            bit last;
            user        = (m_pix == 4);
            last        = (m_pix % LW) == 0;
            m_pend      = 1;
            m_pend_w    = {user, last, m_acc};
            m_pend_fend = (m_pix == LW * FL);
            if (m_pend_fend && !frame_start && !drop) m_state = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk_slow);
      if (model_live) begin
        bit ev;
        ev = exp_tvalid(edge_no);
        check("tvalid", 64'(m_axis_tvalid), 64'(ev));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("frame_count", 64'(frame_count), 64'(m_fc));
        if (ev)
          check("beat", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(q[0].w));
        if (stall_pending && !rst)
          check("hold", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}),
                64'({1'b1, stall_word}));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic fs, input logic v, input logic [7:0] d, input logic rdy);
    @(negedge clk_slow);
    frame_start   = fs;
    valid         = v;
    data          = d;
    m_axis_tready = rdy;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic send_frame(input logic [7:0] base, input int gap, input logic rdy);
    tick(1'b1, 1'b1, base, rdy);
    for (int i = 1; i < 16; i++) begin
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 8'h00, rdy);
      tick(1'b0, 1'b1, base + 8'(i), rdy);
    end
  endtask

  function automatic logic [33:0] frame_word(input logic [7:0] base, input int k);
    logic [7:0] b;
    b = base + 8'(4 * k);
    return {(k == 0), (k % 2 == 1), b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic check_frame_beats(input string name, input int first, input logic [7:0] base);
    check({name, "_count"}, 64'(obs.size() >= first + 4), 64'(1));
    for (int k = 0; k < 4; k++)
      if (obs.size() > first + k)
        check(name, 64'(obs[first + k]), 64'(frame_word(base, k)));
  endtask

  initial begin
    logic [33:0] basic_exp [4];
    basic_exp[0] = 34'h2_03020100;
    basic_exp[1] = 34'h1_07060504;
    basic_exp[2] = 34'h0_0B0A0908;
    basic_exp[3] = 34'h1_0F0E0D0C;

    rst = 1'b1; frame_start = 1'b0; valid = 1'b0; data = 8'h00; m_axis_tready = 1'b0;
    idle(2, 1'b0);
    check("reset_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("reset_tdata", 64'(m_axis_tdata), 64'(0));
    check("reset_overflow", 64'(overflow), 64'(0));
    check("reset_frame_count", 64'(frame_count), 64'(0));
    rst = 1'b0;
    idle(2, 1'b1);

    // basic frame
    obs.delete();
    send_frame(8'h00, 0, 1'b1);
    idle(6, 1'b1);
    check("basic_count", 64'(obs.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (obs.size() > k) check("basic_word", 64'(obs[k]), 64'(basic_exp[k]));
    check("basic_frame_count", 64'(frame_count), 64'(1));
    // back in IDLE: bytes without frame_start are ignored
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'hAA, 1'b1);
    idle(6, 1'b1);
    check("idle_ignores", 64'(obs.size()), 64'(4));

    // gapped input
    obs.delete();
    send_frame(8'h00, 2, 1'b1);
    idle(6, 1'b1);
    check("gapped_count", 64'(obs.size()), 64'(4));
    check_frame_beats("gapped_word", 0, 8'h00);
    check("gapped_frame_count", 64'(frame_count), 64'(2));

    // backpressure without loss: stall during first 12 bytes
    obs.delete();
    tick(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 12; i++) tick(1'b0, 1'b1, 8'(i), 1'b0);
    for (int i = 12; i < 16; i++) tick(1'b0, 1'b1, 8'(i), 1'b1);
    idle(8, 1'b1);
    check("bp_count", 64'(obs.size()), 64'(4));
    check_frame_beats("bp_word", 0, 8'h00);
    check("bp_overflow", 64'(overflow), 64'(0));

    // overflow: four words fill the FIFO, the fifth is dropped
    obs.delete();
    send_frame(8'h00, 0, 1'b0);
    idle(4, 1'b0);
    send_frame(8'h40, 0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 8'h55, 1'b0);
    check("ovf_set", 64'(overflow), 64'(1));
    idle(10, 1'b1);
    check("ovf_drain_count", 64'(obs.size()), 64'(4));
    check_frame_beats("ovf_drain", 0, 8'h00);
    check("ovf_frame_count", 64'(frame_count), 64'(4));
    obs.delete();
    send_frame(8'h20, 0, 1'b1);
    idle(6, 1'b1);
    check_frame_beats("ovf_next", 0, 8'h20);
    check("ovf_sticky", 64'(overflow), 64'(1));
    check("ovf_next_frame_count", 64'(frame_count), 64'(5));

    // resync mid-frame
    obs.delete();
    tick(1'b1, 1'b1, 8'h00, 1'b1);
    for (int i = 1; i < 6; i++) tick(1'b0, 1'b1, 8'(i), 1'b1);
    send_frame(8'h10, 0, 1'b1);
    idle(6, 1'b1);
    check("resync_count", 64'(obs.size()), 64'(5));
    if (obs.size() > 1) begin
      check("resync_first", 64'(obs[0]), 64'(34'h2_03020100));
      check("resync_second", 64'(obs[1]), 64'(34'h2_13121110));
    end
    check("resync_frame_count", 64'(frame_count), 64'(6));

    // reset mid-frame with two words queued
    tick(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 10; i++) tick(1'b0, 1'b1, 8'(i), 1'b0);
    idle(3, 1'b0);
    check("pre_reset_tvalid", 64'(m_axis_tvalid), 64'(1));
    @(negedge clk_slow);
    rst = 1'b1; valid = 1'b0; frame_start = 1'b0;
    @(negedge clk_slow);
    check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_mid_frame_count", 64'(frame_count), 64'(0));
    rst = 1'b0;
    obs.delete();
    send_frame(8'h00, 0, 1'b1);
    idle(6, 1'b1);
    check("after_rst_count", 64'(obs.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      if (obs.size() > k) check("after_rst_word", 64'(obs[k]), 64'(basic_exp[k]));

    // randomized traffic, checked by the per-cycle model comparison
    for (int phase = 0; phase < 40; phase++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 3) * 33 + 1;
      for (int c = 0; c < 100; c++) begin
        logic fs;
        logic v;
        logic r;
        fs = ($urandom_range(0, 39) == 0);
        v  = ($urandom_range(0, 99) < 70);
        r  = ($urandom_range(0, 99) < rdy_pct);
        if ($urandom_range(0, 799) == 0) begin
          @(negedge clk_slow);
          rst = 1'b1;
          @(negedge clk_slow);
          rst = 1'b0;
        end
        tick(fs, v, 8'($urandom_range(0, 255)), r);
      end
    end
    idle(20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
